// File: rtl/falu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : falu_pkg
//  Description : Shared definitions for the FALU request sequencer: FALU
//                operation codes, the quiet-NaN substitute result, FSM state
//                encoding, response flag bit positions and op-code helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package falu_pkg;

    // FALU operation codes; 0 means "no operation" on the FALU port.
    localparam logic [3:0] OP_NONE     = 4'd0;
    localparam logic [3:0] OP_ADD      = 4'd1;
    localparam logic [3:0] OP_SUB      = 4'd2;
    localparam logic [3:0] OP_MUL      = 4'd3;
    localparam logic [3:0] OP_DIV      = 4'd4;
    localparam logic [3:0] OP_SQRT     = 4'd5;
    localparam logic [3:0] OP_FP2INT   = 4'd6;
    localparam logic [3:0] OP_INT2FP   = 4'd7;
    localparam logic [3:0] OP_FP2USINT = 4'd8;
    localparam logic [3:0] OP_USINT2FP = 4'd9;

    // Result substituted for illegal ops and watchdog expiry.
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Sequencer FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Bit positions inside rsp_flags.
    localparam int FLG_EXC = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 2;
    localparam int FLG_TMO = 3;

    // Div and sqrt run until FALU signals completion.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_SQRT);
    endfunction

    // Only these codes are ever presented to FALU.
    function automatic logic is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT,
            OP_FP2INT, OP_INT2FP, OP_FP2USINT, OP_USINT2FP: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/falu_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : falu_req_fifo
//  Description : Synchronous request FIFO, DEPTH entries of WIDTH bits.
//                Pointers wrap by natural overflow; a separate occupancy
//                register provides full/empty. Read data shows the head entry
//                combinationally. Push while full and pop while empty are
//                ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_i, wdata_i - write request and data
//                pop_i           - remove head entry
//                rdata_o         - head entry
//                full_o, empty_o - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module falu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/falu_req_seq.sv
`default_nettype none
// ============================================================================
//  Module      : falu_req_seq
//  Description : Request sequencer in front of the FALU floating-point unit.
//                Buffers requests in a FIFO, issues them one at a time,
//                captures result and flags, and returns them in order with the
//                request tag over a valid/ready response port.
//                Optional feature macro: FALU_SEQ_TIMEOUT_EN - adds a
//                WAIT_MAX-cycle watchdog on div/sqrt (flags 4'b1001 on expiry).
//  Ports       : clk, rst                    - clock, sync active-high reset
//                req_valid/req_ready/req_*   - request push port
//                falu_op/falu_a/falu_b       - FALU command (op 0 when idle)
//                falu_result/exc/ovf/unf/done- FALU returns
//                rsp_valid/rsp_ready/rsp_*   - response port
//  Revision    : 1.0 - initial release
// ============================================================================
module falu_req_seq
    import falu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int WAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       falu_op,
    output logic [31:0]      falu_a,
    output logic [31:0]      falu_b,
    input  logic [31:0]      falu_result,
    input  logic             falu_exc,
    input  logic             falu_ovf,
    input  logic             falu_unf,
    input  logic             falu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int ENT_W = 4 + 32 + 32 + TAG_W;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      rsp_result_q;
    logic [3:0]       rsp_flags_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic             w_capture;
    logic [31:0]      w_cap_result;
    logic [3:0]       w_cap_flags;
    logic             w_tmo;

    // ------------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------------
    falu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid),
        .wdata_i ({req_op, req_a, req_b, req_tag}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign req_ready = !w_full;

    // ------------------------------------------------------------------------
    // Optional div/sqrt watchdog
    // ------------------------------------------------------------------------
`ifdef FALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    // Cleared on every pop so each op starts counting from zero; it counts
    // EXEC cycles and expires on the last permitted one.
    always_ff @(posedge clk) begin
        if (rst || w_pop) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_EXEC) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign w_tmo = (wait_cnt_q == CNT_W'(WAIT_MAX - 1));
`else
    assign w_tmo = 1'b0;

    // WAIT_MAX only matters with the watchdog; keep it referenced so the
    // parameter list stays identical in both builds.
    if (WAIT_MAX < 1) begin : g_wait_max_invalid
    end
`endif

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_cap_result = QNAN;
        w_cap_flags  = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!is_legal(op_q)) begin
                    w_capture            = 1'b1;
                    w_cap_flags[FLG_EXC] = 1'b1;
                end else if (!is_multicycle(op_q) || falu_done || falu_exc) begin
                    w_capture            = 1'b1;
                    w_cap_result         = falu_result;
                    w_cap_flags[FLG_EXC] = falu_exc;
                    w_cap_flags[FLG_OVF] = falu_ovf;
                    w_cap_flags[FLG_UNF] = falu_unf;
                end else if (w_tmo) begin
                    w_capture            = 1'b1;
                    w_cap_flags[FLG_EXC] = 1'b1;
                    w_cap_flags[FLG_TMO] = 1'b1;
                end
                if (w_capture) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NONE;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
        end else begin
            state_q <= state_d;
            if (w_pop) begin
                {op_q, a_q, b_q, tag_q} <= w_head;
            end
            // Response registers are separate from the op registers so a
            // pop out of RESP cannot disturb the response being presented.
            if (w_capture) begin
                rsp_result_q <= w_cap_result;
                rsp_flags_q  <= w_cap_flags;
                rsp_tag_q    <= tag_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Illegal codes are never shown to FALU.
    assign falu_op    = ((state_q == ST_EXEC) && is_legal(op_q)) ? op_q : OP_NONE;
    assign falu_a     = a_q;
    assign falu_b     = b_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_tag    = rsp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_falu_req_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_falu_req_seq
//  Description : Self-checking bench for falu_req_seq. A behavioural FALU
//                mock answers commands; a scoreboard queue holds expected
//                responses pushed at request time and a negedge monitor pops
//                and compares on each response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_falu_req_seq;

    localparam int DEPTH    = 4;
    localparam int TAG_W    = 4;
    localparam int WAIT_MAX = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [3:0]       falu_op;
    logic [31:0]      falu_a;
    logic [31:0]      falu_b;
    logic [31:0]      falu_result;
    logic             falu_exc;
    logic             falu_ovf;
    logic             falu_unf;
    logic             falu_done;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;

    always #5 clk = ~clk;

    falu_req_seq #(
        .DEPTH    (DEPTH),
        .TAG_W    (TAG_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .falu_op     (falu_op),
        .falu_a      (falu_a),
        .falu_b      (falu_b),
        .falu_result (falu_result),
        .falu_exc    (falu_exc),
        .falu_ovf    (falu_ovf),
        .falu_unf    (falu_unf),
        .falu_done   (falu_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_tag     (rsp_tag)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // ------------------------------------------------------------------------
    // FALU mock: arbitrary but deterministic arithmetic, plus the two
    // real-valued cases the directed tests rely on.
    // ------------------------------------------------------------------------
    function automatic logic [34:0] fmodel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        e, o, u;
        if (op == 4'd1 && a == 32'h3F80_0000 && b == 32'h4000_0000)      r = 32'h4040_0000;
        else if (op == 4'd4 && a == 32'h40C0_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
        else r = (a ^ {b[15:0], b[31:16]}) + {28'h0, op};
        e = (a[3:0] == 4'hA);
        o = a[5] & b[5];
        u = a[6] & b[6];
        return {u, o, e, r};
    endfunction

    logic hang      = 1'b0;
    int   fixed_lat = 0;
    int   mc_lat    = 5;
    int   mc_cnt    = 0;
    logic spur      = 1'b0;
    logic mock_mc;

    assign mock_mc = (falu_op == 4'd4) || (falu_op == 4'd5);

    always @(posedge clk) begin
        mc_cnt <= mock_mc ? mc_cnt + 1 : 0;
        if (!mock_mc) mc_lat <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 10));
        spur <= ($urandom_range(0, 3) == 0);
    end

    // Spurious done pulses outside div/sqrt must be ignored by the DUT.
    assign falu_done = mock_mc ? (!hang && (mc_cnt == mc_lat)) : spur;

    always_comb begin
        if (falu_op == 4'd0) begin
            falu_result = 32'hDEAD_BEEF;
            falu_exc    = 1'b1;
            falu_ovf    = 1'b1;
            falu_unf    = 1'b1;
        end else begin
            {falu_unf, falu_ovf, falu_exc, falu_result} = fmodel(falu_op, falu_a, falu_b);
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0]      res;
        logic [3:0]       flg;
        logic [TAG_W-1:0] tag;
        int               push_cyc;
        int               lat;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t expect_rsp(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                        input logic tmo);
        exp_t        e;
        logic [34:0] f;
        e.tag = tag;
        if (op < 4'd1 || op > 4'd9) begin
            e.res = 32'h7FC0_0000;
            e.flg = 4'b0001;
        end else if (tmo) begin
            e.res = 32'h7FC0_0000;
            e.flg = 4'b1001;
        end else begin
            f     = fmodel(op, a, b);
            e.res = f[31:0];
            e.flg = {1'b0, f[34:32]};
        end
        e.push_cyc = 0;
        e.lat      = -1;
        return e;
    endfunction

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int lat, input logic tmo,
                        input logic rnd_rdy);
        exp_t e;
        int   t;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        t         = 0;
        while (!req_ready && t < 200) begin
            if (rnd_rdy) rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            fail_now("push_accept");
        end else begin
            e          = expect_rsp(op, a, b, tag, tmo);
            e.push_cyc = cyc;
            e.lat      = lat;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) fail_now(nm);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    logic [3:0]  prev_op = '0;
    logic [31:0] prev_a  = '0;
    logic [31:0] prev_b  = '0;
    int          op_nz   = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got result %h flags %h tag %h, expected none",
                             rsp_result, rsp_flags, rsp_tag);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_flags", {28'h0, rsp_flags}, {28'h0, e.flg});
                    chk("rsp_tag", {28'h0, rsp_tag}, {28'h0, e.tag});
                    if (e.lat >= 0) chk("rsp_latency", cyc - e.push_cyc, e.lat);
                end
            end
            if (falu_op != 4'd0) begin
                op_nz <= op_nz + 1;
                chk("falu_op_legal", {31'h0, (falu_op <= 4'd9)}, 32'h1);
            end
            if ((falu_op == 4'd4 || falu_op == 4'd5) && (prev_op == 4'd4 || prev_op == 4'd5)) begin
                chk("mc_op_stable", {28'h0, falu_op}, {28'h0, prev_op});
                chk("mc_a_stable", falu_a, prev_a);
                chk("mc_b_stable", falu_b, prev_b);
            end
        end
        prev_op <= falu_op;
        prev_a  <= falu_a;
        prev_b  <= falu_b;
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stim
        int snap;
        logic [3:0] op;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_result", rsp_result, 32'h0);
        chk("reset_rsp_flags", {28'h0, rsp_flags}, 32'h0);
        chk("reset_rsp_tag", {28'h0, rsp_tag}, 32'h0);
        chk("reset_falu_op", {28'h0, falu_op}, 32'h0);
        chk("reset_falu_a", falu_a, 32'h0);
        chk("reset_falu_b", falu_b, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single add: one FALU cycle, response three cycles after push.
        rsp_ready = 1'b1;
        snap = op_nz;
        push(4'd1, 32'h3F80_0000, 32'h4000_0000, 4'd3, 3, 1'b0, 1'b0);
        drain("add_drain");
        chk("add_op_cycles", op_nz - snap, 1);

        // Div with a 12-cycle FALU: 13 EXEC cycles, latency 2 + 12 + 1.
        fixed_lat = 12;
        repeat (2) @(posedge clk);
        #1;
        snap = op_nz;
        push(4'd4, 32'h40C0_0000, 32'h4000_0000, 4'd5, 15, 1'b0, 1'b0);
        drain("div_drain");
        chk("div_op_cycles", op_nz - snap, 13);
        fixed_lat = 0;

        // Illegal op: never reaches FALU.
        snap = op_nz;
        push(4'hF, $urandom, $urandom, 4'd7, 3, 1'b0, 1'b0);
        drain("illegal_drain");
        chk("illegal_op_cycles", op_nz - snap, 0);

        // Backpressure: one in RESP plus DEPTH held fills the sequencer.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'd1, $urandom, $urandom, TAG_W'(i + 8), -1, 1'b0, 1'b0);
        end
        chk("bp_req_ready_low", {31'h0, req_ready}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_req_ready_held", {31'h0, req_ready}, 32'h0);
        chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rsp_ready = 1'b1;
        drain("bp_drain");

`ifdef FALU_SEQ_TIMEOUT_EN
        // Sqrt that never completes: watchdog after WAIT_MAX EXEC cycles.
        hang = 1'b1;
        push(4'd5, $urandom, $urandom, 4'd2, 2 + WAIT_MAX, 1'b1, 1'b0);
        drain("timeout_drain");
        hang = 1'b0;
`endif

        // Randomised traffic with random response backpressure.
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            push(op, $urandom, $urandom, TAG_W'($urandom), -1, 1'b0, 1'b1);
        end
        rsp_ready = 1'b1;
        drain("random_drain");

        // Reset during a div wait with two requests queued.
        hang = 1'b1;
        push(4'd4, 32'h40C0_0000, 32'h4000_0000, 4'd1, -1, 1'b0, 1'b0);
        push(4'd1, $urandom, $urandom, 4'd2, -1, 1'b0, 1'b0);
        push(4'd2, $urandom, $urandom, 4'd3, -1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_falu_op", {28'h0, falu_op}, 32'h4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_falu_op", {28'h0, falu_op}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hang = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_no_stale_valid", {31'h0, rsp_valid}, 32'h0);

        // Sequencer still works after the reset.
        push(4'd3, $urandom, $urandom, 4'd9, 3, 1'b0, 1'b0);
        drain("post_rst_drain");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "global watchdog");
    end

endmodule
`default_nettype wire

// File: doc/falu_req_seq.md
# falu_req_seq

Request sequencer sitting directly upstream of the FALU floating-point unit. Buffers incoming FP operation requests in a small FIFO and issues them to FALU one at a time. Single-cycle ops are captured in the issue cycle; div/sqrt are held stable until FALU reports completion. Returns each result, with exception/overflow/underflow flags and the request tag, over a valid/ready response port.

## Interface
- DEPTH, 4: request FIFO entries (power of two, ≥2)
- TAG_W, 4: request tag width
- WAIT_MAX, 64: watchdog limit in cycles for div/sqrt (only with `FALU_SEQ_TIMEOUT_EN`)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset; integrator drives the FALU `rst_n` from `~rst`
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_op  in  4  1 add, 2 sub, 3 mul, 4 div, 5 sqrt, 6 fp2int, 7 int2fp, 8 fp2usint, 9 usint2fp
- req_a, req_b  in  32  operands (b ignored for unary ops)
- req_tag  in  TAG_W  returned unchanged with the response
- falu_op  out  4  FALU option; 0 when not executing
- falu_a, falu_b  out  32  FALU operands
- falu_result  in  32  FALU result
- falu_exc, falu_ovf, falu_unf  in  1  FALU flags
- falu_done  in  1  FALU div/sqrt completion
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  32  captured result
- rsp_flags  out  4  {timeout, underflow, overflow, exception}
- rsp_tag  out  TAG_W  tag of the completed request

## Operation
- Push when req_valid & req_ready. req_ready = !full, derived from the registered count.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into op/a/b/tag registers and go to EXEC.
  - EXEC: falu_op/falu_a/falu_b are driven from registers and stay stable for the whole state.
    - Ops 1–3 and 6–9: capture falu_result and flags at the clock edge ending the first EXEC cycle, then go to RESP.
    - Ops 4–5: remain in EXEC until falu_done | falu_exc is sampled high, then capture and go to RESP.
  - RESP: rsp_valid = 1, outputs held. On rsp_ready: if FIFO is non-empty, pop and go to EXEC; otherwise go to IDLE.
- Illegal ops (0, 10–15):
  - accepted into the FIFO
  - never driven onto falu_op (it stays 0)
  - EXEC lasts one cycle and captures result 32'h7FC00000 with flags 4'b0001
- Simultaneous push and pop are allowed at any occupancy. A push while full is ignored; req_ready is already low in that case.
- Responses complete strictly in request order.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty, req_ready = 1
  - rsp_valid = 0, rsp_result = 0, rsp_flags = 0, rsp_tag = 0
  - falu_op = 0, falu_a = 0, falu_b = 0
- Latency from push to rsp_valid, simple op into an empty sequencer: 3 cycles (push, IDLE pop, EXEC).
- Div/sqrt latency: 2 + FALU latency + 1.
- Sustained throughput, simple ops with rsp_ready held high: one result per 2 cycles.
- Reset mid-operation: any in-flight op and all FIFO contents are discarded with no response. falu_op = 0 from the cycle after the reset edge.
- falu_done while not in EXEC with op 4/5: ignored.

## Configuration
- `FALU_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in EXEC for div/sqrt.
  - If WAIT_MAX cycles elapse without falu_done|falu_exc, capture 32'h7FC00000 with flags 4'b1001 and go to RESP.
- `FALU_SEQ_TIMEOUT_EN` undefined: no counter is present, the sequencer waits indefinitely, and rsp_flags[3] is tied to 0.

## Structure
- Shared package `falu_pkg`:
  - op-code localparams (OP_ADD … OP_USINT2FP)
  - is_multicycle function
  - QNAN = 32'h7FC00000
  - FSM state typedef
  - flag bit indices
- Sub-module `falu_req_fifo` (DEPTH × (4+32+32+TAG_W)):
  - synchronous FIFO with full/empty/count
  - pointer wrap by natural overflow of log2(DEPTH)-bit pointers plus a count register

## Test plan
- Add 3F800000 + 40000000, tag 3, rsp_ready = 1:
  - falu_op = 1 for exactly one cycle
  - rsp_valid 3 cycles after push, rsp_result = 40400000, flags 0, tag 3
- Div 40C00000 / 40000000 with a FALU model asserting falu_done after 12 cycles:
  - falu_op = 4 and operands stable throughout
  - response 40400000, flags 0
- Op 4'hF:
  - falu_op never non-zero
  - response 7FC00000, flags 4'b0001
- Backpressure: rsp_ready = 0, push 5 requests:
  - req_ready falls after the FIFO fills (DEPTH held plus one in RESP)
  - release rsp_ready: all responses arrive in order with matching tags
- Timeout (macro defined, WAIT_MAX = 16): sqrt with falu_done tied low gives a response 7FC00000 with flags 4'b1001 after 16 EXEC cycles.
- Assert rst during the div wait with 2 queued requests:
  - next cycle falu_op = 0, req_ready = 1, rsp_valid = 0
  - no stale response afterwards
